// File: rtl/fm_tap_ctrl_f1.sv
`default_nettype none
// ============================================================================
//  Module   : fm_tap_ctrl_f1
//  Brief    : Delay-line tap search controller. Steps a 3-bit tap index up or
//             down on phase-detector samples, waiting a settle interval after
//             every tap change. It ends in LOCK on a balanced sample, or in
//             FAIL once its step budget is exhausted. The one-hot readback
//             from the tap decoder is cross-checked against the expected tap.
//  Revision : 1.0 - initial release
// ============================================================================
module fm_tap_ctrl_f1 #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pd_valid,
    input  logic       pd_up,
    input  logic       pd_dn,
    input  logic [7:0] T_fb,
    output logic [2:0] Q,
    output logic [3:0] count,
    output logic [2:0] q_fb,
    output logic       busy,
    output logic       locked,
    output logic       fail,
    output logic       onehot_err
);

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYC);
    localparam logic [2:0] c_TAP_CENTER  = 3'd4;
    localparam logic [3:0] c_LAST_STEP   = 4'd5;
    localparam logic [3:0] c_FAIL_COUNT  = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_LOCK   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_q;
    logic [2:0] w_q_nxt;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic [3:0] r_settle;
    logic [3:0] w_settle_nxt;
    logic       r_busy;
    logic       r_locked;
    logic       r_fail;
    logic       r_oh_err;
    logic       w_oh_err_nxt;
    logic       w_restart;

    logic [2:0] w_qfb;
    logic       w_onehot;
    logic [2:0] w_exp_tap;
    logic       w_chk_en;
    logic       w_mismatch;

    // Readback priority encoder: highest set bit wins, zero when nothing is set
    always_comb begin
        w_qfb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (T_fb[i]) begin
                w_qfb = 3'(i);
            end
        end
    end

    // Readback consistency: decoder falls back to the centre tap once the
    // step budget is blown, so the expected tap follows that rule
    always_comb begin
        w_onehot   = (T_fb != 8'd0) && ((T_fb & (T_fb - 8'd1)) == 8'd0);
        w_exp_tap  = (r_count > c_LAST_STEP) ? c_TAP_CENTER : r_q;
        w_chk_en   = (r_state == ST_SAMPLE) || (r_state == ST_LOCK) ||
                     (r_state == ST_FAIL);
        w_mismatch = !w_onehot || (w_qfb != w_exp_tap);
    end

    // Next-state and datapath decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_count_nxt  = r_count;
        w_settle_nxt = r_settle;
        w_restart    = 1'b0;

        case (r_state)
            ST_IDLE, ST_LOCK, ST_FAIL: begin
                if (start) begin
                    w_restart = 1'b1;
                end
            end

            ST_SETTLE: begin
                // pd_valid is deliberately ignored while the line settles
                if (r_settle > 4'd1) begin
                    w_settle_nxt = r_settle - 4'd1;
                end else begin
                    w_settle_nxt = 4'd0;
                    w_state_nxt  = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (pd_valid) begin
                    if (pd_up != pd_dn) begin
                        if (r_count >= c_LAST_STEP) begin
                            // Budget exhausted: tap frozen, counter capped
                            w_count_nxt = c_FAIL_COUNT;
                            w_state_nxt = ST_FAIL;
                        end else begin
                            w_count_nxt  = r_count + 4'd1;
                            w_settle_nxt = c_SETTLE_LOAD;
                            w_state_nxt  = ST_SETTLE;
                            if (pd_up) begin
                                w_q_nxt = (r_q == 3'd7) ? r_q : r_q + 3'd1;
                            end else begin
                                w_q_nxt = (r_q == 3'd0) ? r_q : r_q - 3'd1;
                            end
                        end
                    end else begin
                        w_state_nxt = ST_LOCK;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_restart) begin
            w_state_nxt  = ST_SETTLE;
            w_q_nxt      = c_TAP_CENTER;
            w_count_nxt  = 4'd0;
            w_settle_nxt = c_SETTLE_LOAD;
        end

        // Sticky error: cleared only by an accepted start
        if (w_restart) begin
            w_oh_err_nxt = 1'b0;
        end else begin
            w_oh_err_nxt = r_oh_err | (w_chk_en & w_mismatch);
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_q      <= c_TAP_CENTER;
            r_count  <= 4'd0;
            r_settle <= 4'd0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_oh_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_count  <= w_count_nxt;
            r_settle <= w_settle_nxt;
            r_busy   <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
            r_locked <= (w_state_nxt == ST_LOCK);
            r_fail   <= (w_state_nxt == ST_FAIL);
            r_oh_err <= w_oh_err_nxt;
        end
    end

    assign Q          = r_q;
    assign count      = r_count;
    assign q_fb       = w_qfb;
    assign busy       = r_busy;
    assign locked     = r_locked;
    assign fail       = r_fail;
    assign onehot_err = r_oh_err;

endmodule
`default_nettype wire

// File: doc/fm_tap_ctrl_f1.md
FM_TAP_CTRL_F1 -- requirements
Module: fm_tap_ctrl_f1

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYC, default 4, the number of cycles to wait after each tap change before a phase-detector sample is accepted (legal range 1..15).
REQ-002 The block SHALL have these ports:
- clk, input, 1: the only clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to begin a tap search.
- pd_valid, input, 1: a phase-detector sample is present this cycle.
- pd_up, input, 1: phase detector asks for a later tap.
- pd_dn, input, 1: phase detector asks for an earlier tap.
- T_fb, input, 8: one-hot tap-enable readback from the 3-to-8 tap decoder.
- Q, output, 3: tap index, registered.
- count, output, 4: search step counter, registered.
- q_fb, output, 3: binary encoding of T_fb, combinational.
- busy, output, 1: a search is in progress.
- locked, output, 1: the search ended on a balanced sample.
- fail, output, 1: the search ran out of steps.
- onehot_err, output, 1: sticky readback mismatch flag.

Function
REQ-003 The state machine SHALL have the states IDLE, SETTLE, SAMPLE, LOCK and FAIL.
REQ-004 IDLE -> SETTLE SHALL occur on start; on this transition Q SHALL become 4, count SHALL become 0, the settle counter SHALL load SETTLE_CYC, and onehot_err SHALL clear.
REQ-005 In SETTLE the settle counter SHALL decrement once per cycle, the block SHALL ignore pd_valid, and the block SHALL move to SAMPLE the cycle after the counter reaches 1.
REQ-006 In SAMPLE with pd_valid=0 the block SHALL hold all registers.
REQ-007 In SAMPLE, pd_valid=1 with pd_up=1 and pd_dn=0 SHALL be an up step: Q+1, saturating at 7.
REQ-008 In SAMPLE, pd_valid=1 with pd_dn=1 and pd_up=0 SHALL be a down step: Q-1, saturating at 0.
REQ-009 Each step SHALL increment count, reload the settle counter and move to SETTLE, including a step that is saturated and leaves Q unchanged.
REQ-010 In SAMPLE, pd_valid=1 with pd_up equal to pd_dn (both 0 or both 1) SHALL move to LOCK with Q and count held.
REQ-011 A step requested while count=5 SHALL leave Q unchanged, set count to 6 and move to FAIL; count SHALL never exceed 6.
REQ-012 In LOCK and FAIL the block SHALL hold Q and count, and start SHALL restart the search exactly as in REQ-004.
REQ-013 start SHALL be ignored in SETTLE and SAMPLE.
REQ-014 The status outputs SHALL be registered and follow the state: busy=1 in SETTLE or SAMPLE, locked=1 only in LOCK, fail=1 only in FAIL, all zero in IDLE.
REQ-015 q_fb SHALL be the index of the single set bit of T_fb; when T_fb is not one-hot, q_fb SHALL be the index of the highest set bit, or 0 when T_fb=0.
REQ-016 The expected tap SHALL be Q when count<=5 and 4 when count>5, matching the decoder fallback.
REQ-017 In SAMPLE, LOCK and FAIL, onehot_err SHALL be set when T_fb is not one-hot or q_fb differs from the expected tap.
REQ-018 Once set, onehot_err SHALL remain set until reset or until start is accepted; it SHALL never be set in IDLE or SETTLE.
REQ-019 Latency from the start cycle to the first accepted sample SHALL be SETTLE_CYC+1 cycles.

Reset
REQ-020 While rst_n=0, and regardless of clk, the outputs SHALL be: Q=4, count=0, busy=0, locked=0, fail=0, onehot_err=0, state=IDLE, settle counter=0.
REQ-021 Reset asserted mid-search SHALL abort the search immediately with no residual state.
REQ-022 After rst_n deasserts, the first active edge SHALL obey REQ-004 through REQ-014.

Verification
REQ-023 Basic lock: start, then one pd_up sample, then a balanced sample -> Q=5, count=1, locked=1, busy=0, onehot_err=0 when T_fb=8'b00100000.
REQ-024 Step exhaustion: start, then six consecutive pd_dn samples -> Q walks 3,2,1,0,0; count=6; fail=1; the expected tap becomes 4, and T_fb=8'h10 gives no error.
REQ-025 Settle masking: SETTLE_CYC=4 and pd_valid/pd_up held at 1 continuously from start -> exactly one step per 5 cycles; no sample is accepted during SETTLE.
REQ-026 Readback fault: in LOCK with Q=4, T_fb=8'b00011000 -> onehot_err=1 and it stays set; a new start clears it.
REQ-027 Mid-search reset: rst_n pulled low during SETTLE with Q=6 -> Q=4, count=0 and all flags 0 without waiting for a clk edge; start is ignored while busy=1.
